wb_write_arbiter: RTL and testbench

- Producer side of the register file's write port.
- Merges two write-back sources into the single RegWrite/WN/WD write port:
  - in-order pipeline WB-stage results;
  - out-of-order results from the long-latency mul/div unit, via valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a per-register busy scoreboard that the hazard unit queries to stall readers of pending destinations.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_write_arbiter_if.sv | 36 +++
 rtl/wb_fifo.sv | 48 ++++
 rtl/wb_write_arbiter.sv | 109 ++++++++++
 tb/tb_wb_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the write-back entry type for the register-file write port.
package wb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned REG_COUNT = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] wn;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the pipeline / mul-div producers, the hazard unit and the write arbiter.
interface wb_write_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);

    logic                    wb_we;
    logic [ADDR_W-1:0]       wb_wn;
    logic [DATA_W-1:0]       wb_wd;
    logic                    ll_issue;
    logic [ADDR_W-1:0]       ll_issue_wn;
    logic                    ll_valid;
    logic [ADDR_W-1:0]       ll_wn;
    logic [DATA_W-1:0]       ll_wd;
    logic                    ll_ready;
    logic                    RegWrite;
    logic [ADDR_W-1:0]       WN;
    logic [DATA_W-1:0]       WD;
    logic [ADDR_W-1:0]       RN1;
    logic [ADDR_W-1:0]       RN2;
    logic                    busy1;
    logic                    busy2;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output wb_we, wb_wn, wb_wd, ll_issue, ll_issue_wn, ll_valid, ll_wn, ll_wd, RN1, RN2,
        input  ll_ready, RegWrite, WN, WD, busy1, busy2, fifo_count
    );

    modport slave (
        input  wb_we, wb_wn, wb_wd, ll_issue, ll_issue_wn, ll_valid, ll_wn, ll_wd, RN1, RN2,
        output ll_ready, RegWrite, WN, WD, busy1, busy2, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; pointers carry an extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  wb_entry_t               wdata_i,
    input  logic                    pop_i,
    output wb_entry_t               rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

    wb_entry_t        mem_q [Depth];
    logic [AddrW:0]   wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == DepthCnt);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline WB writes and buffered mul/div results onto the register-file write port,
// and tracks pending long-latency destinations. Define WB_BYPASS_EN for the empty-FIFO bypass.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_write_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    wb_entry_t             head, ll_entry;
    logic                  fifo_full, fifo_empty;
    logic [CntW-1:0]       count;
    logic                  wb_eff, ll_fire, bypass, push, pop;
    logic                  clr_en;
    logic [ADDR_W-1:0]     clr_wn;
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]     wn_q, wn_d;
    logic [DATA_W-1:0]     wd_q, wd_d;

    assign wb_eff   = bus.wb_we && (bus.wb_wn != '0);
    assign ll_fire  = bus.ll_valid && !fifo_full;
    assign ll_entry = '{wn: bus.ll_wn, wd: bus.ll_wd};

`ifdef WB_BYPASS_EN
    assign bypass = ll_fire && fifo_empty && !wb_eff;
`else
    assign bypass = 1'b0;
`endif

    assign push = ll_fire && !bypass;
    // The pipeline never stalls, so the FIFO only drains on idle WB cycles.
    assign pop  = !wb_eff && !fifo_empty;

    wb_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (ll_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        reg_write_d = 1'b0;
        wn_d        = wn_q;
        wd_d        = wd_q;
        clr_en      = 1'b0;
        clr_wn      = head.wn;
        if (wb_eff) begin
            reg_write_d = 1'b1;
            wn_d        = bus.wb_wn;
            wd_d        = bus.wb_wd;
        end else if (pop) begin
            reg_write_d = (head.wn != '0);
            wn_d        = head.wn;
            wd_d        = head.wd;
            clr_en      = 1'b1;
            clr_wn      = head.wn;
        end else if (bypass) begin
            reg_write_d = (bus.ll_wn != '0);
            wn_d        = bus.ll_wn;
            wd_d        = bus.ll_wd;
            clr_en      = 1'b1;
            clr_wn      = bus.ll_wn;
        end
    end

    // Set is applied after clear so a re-issue on the commit cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_wn] = 1'b0;
        if (bus.ll_issue) busy_d[bus.ll_issue_wn] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            wn_q        <= '0;
            wd_q        <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wn_q        <= wn_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ll_ready   = !fifo_full;
    assign bus.RegWrite   = reg_write_q;
    assign bus.WN         = wn_q;
    assign bus.WD         = wd_q;
    assign bus.busy1      = busy_q[bus.RN1];
    assign bus.busy2      = busy_q[bus.RN2];
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model checked every cycle, plus
// directed literal checks. Honours WB_BYPASS_EN the same way as the design.
module tb_wb_write_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs, pending results queue, busy flags.
    wb_entry_t   mq[$];
    bit          mbusy[REG_COUNT];
    logic        m_we = 1'b0;
    logic [4:0]  m_wn = '0;
    logic [31:0] m_wd = '0;
    bit          mwb, mfire, mbyp;
    int          mclr;
    wb_entry_t   me;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_we = 1'b0;
            m_wn = '0;
            m_wd = '0;
        end else begin
            mwb   = bus.wb_we && (bus.wb_wn != 0);
            mfire = bus.ll_valid && (mq.size() < DEPTH);
            mbyp  = BYP && mfire && (mq.size() == 0) && !mwb;
            mclr  = -1;
            if (mwb) begin
                m_we = 1'b1;
                m_wn = bus.wb_wn;
                m_wd = bus.wb_wd;
            end else if (mq.size() > 0) begin
                me   = mq.pop_front();
                m_we = (me.wn != 0);
                m_wn = me.wn;
                m_wd = me.wd;
                mclr = int'(me.wn);
            end else if (mbyp) begin
                m_we = (bus.ll_wn != 0);
                m_wn = bus.ll_wn;
                m_wd = bus.ll_wd;
                mclr = int'(bus.ll_wn);
            end else begin
                m_we = 1'b0;
            end
            if (mfire && !mbyp) mq.push_back('{wn: bus.ll_wn, wd: bus.ll_wd});
            if (bus.ll_issue && bus.ll_issue_wn != 0) begin
                assert (!mbusy[bus.ll_issue_wn] || mclr == int'(bus.ll_issue_wn))
                    else $error("protocol: issue to busy register r%0d", bus.ll_issue_wn);
            end
            if (mclr > 0) mbusy[mclr] = 1'b0;
            if (bus.ll_issue && bus.ll_issue_wn != 0) mbusy[bus.ll_issue_wn] = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("RegWrite", 64'(bus.RegWrite), 64'(m_we));
            check("WN", 64'(bus.WN), 64'(m_wn));
            check("WD", 64'(bus.WD), 64'(m_wd));
            check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
            check("ll_ready", 64'(bus.ll_ready), 64'(mq.size() < DEPTH));
            check("busy1", 64'(bus.busy1), 64'(mbusy[bus.RN1]));
            check("busy2", 64'(bus.busy2), 64'(mbusy[bus.RN2]));
        end
    end

    task automatic idle();
        bus.wb_we       = 1'b0;
        bus.wb_wn       = '0;
        bus.wb_wd       = '0;
        bus.ll_issue    = 1'b0;
        bus.ll_issue_wn = '0;
        bus.ll_valid    = 1'b0;
        bus.ll_wn       = '0;
        bus.ll_wd       = '0;
    endtask

    initial begin
        idle();
        bus.RN1 = '0;
        bus.RN2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rst_ll_ready", 64'(bus.ll_ready), 64'd1);

        // Pipeline write path, then a dropped r0 write.
        bus.wb_we = 1'b1;
        bus.wb_wn = 5'd5;
        bus.wb_wd = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wb_RegWrite", 64'(bus.RegWrite), 64'd1);
        check("wb_WN", 64'(bus.WN), 64'd5);
        check("wb_WD", 64'(bus.WD), 64'hDEAD_BEEF);
        bus.wb_wn = 5'd0;
        bus.wb_wd = 32'h1111_1111;
        @(negedge clk);
        check("wb_r0_RegWrite", 64'(bus.RegWrite), 64'd0);
        check("wb_r0_WN_hold", 64'(bus.WN), 64'd5);
        idle();

        // Long-latency result to r7.
        bus.ll_issue    = 1'b1;
        bus.ll_issue_wn = 5'd7;
        bus.RN1         = 5'd7;
        @(negedge clk);
        bus.ll_issue = 1'b0;
        check("ll_busy_set", 64'(bus.busy1), 64'd1);
        bus.ll_valid = 1'b1;
        bus.ll_wn    = 5'd7;
        bus.ll_wd    = 32'h0000_1234;
        @(negedge clk);
        bus.ll_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check("ll_RegWrite", 64'(bus.RegWrite), 64'd1);
        check("ll_WN", 64'(bus.WN), 64'd7);
        check("ll_busy_clr", 64'(bus.busy1), 64'd0);
`else
        check("ll_early_RegWrite", 64'(bus.RegWrite), 64'd0);
        check("ll_fifo_count", 64'(bus.fifo_count), 64'd1);
        check("ll_busy_held", 64'(bus.busy1), 64'd1);
        @(negedge clk);
        check("ll_RegWrite", 64'(bus.RegWrite), 64'd1);
        check("ll_WN", 64'(bus.WN), 64'd7);
        check("ll_WD", 64'(bus.WD), 64'h1234);
        check("ll_busy_clr", 64'(bus.busy1), 64'd0);
`endif

        // Contention: six WB cycles while r10..r13 arrive, r14 must wait.
        for (int i = 0; i < 5; i++) begin
            bus.ll_issue    = 1'b1;
            bus.ll_issue_wn = 5'(10 + i);
            @(negedge clk);
        end
        bus.ll_issue = 1'b0;
        bus.RN1      = 5'd14;
        bus.RN2      = 5'd10;
        for (int c = 0; c < 8; c++) begin
            bus.wb_we    = (c < 6);
            bus.wb_wn    = 5'(20 + c);
            bus.wb_wd    = 32'hA000_0000 + 32'(c);
            bus.ll_valid = 1'b1;
            bus.ll_wn    = 5'(10 + ((c < 4) ? c : 4));
            bus.ll_wd    = 32'hB000_0000 + 32'(bus.ll_wn);
            if (c == 4) begin
                check("cont_ll_ready_full", 64'(bus.ll_ready), 64'd0);
                check("cont_fifo_count", 64'(bus.fifo_count), 64'd4);
            end
            if (c == 7) begin
                check("cont_first_WN", 64'(bus.WN), 64'd10);
                check("cont_first_WD", 64'(bus.WD), 64'hB000_000A);
                check("cont_ll_ready_back", 64'(bus.ll_ready), 64'd1);
            end
            @(negedge clk);
        end
        idle();
        check("cont_WN_r11", 64'(bus.WN), 64'd11);
        @(negedge clk);
        check("cont_WN_r12", 64'(bus.WN), 64'd12);
        @(negedge clk);
        check("cont_WN_r13", 64'(bus.WN), 64'd13);
        @(negedge clk);
        check("cont_WN_r14", 64'(bus.WN), 64'd14);
        check("cont_drained", 64'(bus.fifo_count), 64'd0);

        // Wrap-around: ten back-to-back results through the FIFO.
        for (int i = 1; i <= 10; i++) begin
            bus.ll_issue    = 1'b1;
            bus.ll_issue_wn = 5'(i);
            @(negedge clk);
        end
        bus.ll_issue = 1'b0;
        bus.RN1      = 5'd3;
        bus.RN2      = 5'd8;
        for (int i = 1; i <= 10; i++) begin
            bus.ll_valid = 1'b1;
            bus.ll_wn    = 5'(i);
            bus.ll_wd    = 32'h111 * 32'(i);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        check("wrap_last_WN", 64'(bus.WN), 64'd10);
        check("wrap_last_WD", 64'(bus.WD), 64'hAAA);
        check("wrap_empty", 64'(bus.fifo_count), 64'd0);

        // Set/clear collision on r9.
        bus.RN1         = 5'd9;
        bus.ll_issue    = 1'b1;
        bus.ll_issue_wn = 5'd9;
        @(negedge clk);
        bus.ll_issue = 1'b0;
        bus.ll_valid = 1'b1;
        bus.ll_wn    = 5'd9;
        bus.ll_wd    = 32'h0000_0099;
`ifdef WB_BYPASS_EN
        bus.ll_issue = 1'b1;
        @(negedge clk);
        idle();
`else
        @(negedge clk);
        idle();
        bus.ll_issue    = 1'b1;
        bus.ll_issue_wn = 5'd9;
        @(negedge clk);
        idle();
`endif
        check("coll_RegWrite", 64'(bus.RegWrite), 64'd1);
        check("coll_WN", 64'(bus.WN), 64'd9);
        check("coll_busy_kept", 64'(bus.busy1), 64'd1);

        // Reset with three buffered results and live reservations.
        bus.RN1 = 5'd2;
        bus.RN2 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            bus.ll_issue    = 1'b1;
            bus.ll_issue_wn = 5'(2 + i);
            @(negedge clk);
        end
        bus.ll_issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wb_we    = 1'b1;
            bus.wb_wn    = 5'd30;
            bus.wb_wd    = 32'(i);
            bus.ll_valid = 1'b1;
            bus.ll_wn    = 5'(2 + i);
            bus.ll_wd    = 32'hC000_0000 + 32'(i);
            @(negedge clk);
        end
        bus.ll_valid = 1'b0;
        check("pre_rst_fifo_count", 64'(bus.fifo_count), 64'd3);
        check("pre_rst_busy1", 64'(bus.busy1), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        check("mid_rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("mid_rst_busy1", 64'(bus.busy1), 64'd0);
        check("mid_rst_busy2", 64'(bus.busy2), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_ll_ready", 64'(bus.ll_ready), 64'd1);
        @(negedge clk);
        check("post_rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        check("post_rst_fifo_count", 64'(bus.fifo_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
